// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO-read and valid/ready stream signals for fifo_rd_stream.
// master = the adapter itself, slave = the FIFO plus the stream consumer.
interface fifo_rd_stream_if #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 2
);
  localparam int LW = $clog2(BUF_DEPTH) + 1;

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    level;

  modport master (
    input  fifo_dout, fifo_empty, out_ready,
    output fifo_rd_en, out_data, out_valid, level
  );

  modport slave (
    output fifo_dout, fifo_empty, out_ready,
    input  fifo_rd_en, out_data, out_valid, level
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: 1-cycle-latency FIFO -> first-word-fall-through valid/ready stream.
// Define FIFO_RD_STREAM_FLUSH_EN to add a synchronous active-high flush input.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef FIFO_RD_STREAM_FLUSH_EN
  input  logic flush,
`endif
  fifo_rd_stream_if.master bus
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             pending_q, pending_d;

  logic             flushNow;
  logic             validNow;
  logic             push;
  logic             pop;
  logic             rdEn;
  logic [CW:0]      occupancy;

`ifdef FIFO_RD_STREAM_FLUSH_EN
  assign flushNow = flush;
`else
  assign flushNow = 1'b0;
`endif

  assign validNow = (count_q != '0);

  // A read may only be issued if its word is guaranteed a free slot on arrival.
  always_comb begin
    pop       = validNow & bus.out_ready & ~flushNow;
    push      = pending_q & ~flushNow;
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, pending_q} - {{CW{1'b0}}, pop};
    rdEn      = rst_n & ~bus.fifo_empty & ~flushNow
                & (occupancy < (CW+1)'(BUF_DEPTH));
  end

  always_comb begin
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    pending_d = rdEn;
    if (flushNow) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      pending_q <= pending_d;
    end
  end

  // Storage is deliberately not reset; out_data is meaningless while out_valid=0.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= bus.fifo_dout;
  end

  assign bus.fifo_rd_en = rdEn;
  assign bus.out_valid  = validNow;
  assign bus.out_data   = buf_q[rd_ptr_q];
  assign bus.level      = count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream against a behavioural 32-deep standard FIFO; scoreboard of written words.
// Set FIFO_RD_STREAM_FLUSH_EN to also exercise the flush input.
module tb_fifo_rd_stream;

  logic clk;
  logic rst_n;
  logic fifoRstN;
  logic flushSig;
  logic flushReq;

  logic       fifoWrEn;
  logic [7:0] fifoWrData;
  logic [7:0] fifoDout;
  logic       outReady;
  logic [7:0] fifoMem [32];
  int         fifoCnt, fifoWp, fifoRp;

  logic [7:0] expQ [$];
  int         checks, errors, popCount;
  logic       lastRdEn;

  fifo_rd_stream_if #(.WIDTH(8), .BUF_DEPTH(2)) bus ();

  fifo_rd_stream #(.WIDTH(8), .BUF_DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef FIFO_RD_STREAM_FLUSH_EN
    .flush(flushSig),
`endif
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.fifo_dout  = fifoDout;
  assign bus.fifo_empty = (fifoCnt == 0);
  assign bus.out_ready  = outReady;

  // Standard FIFO: writes become visible the next cycle, read data one cycle after rd_en.
  always @(posedge clk or negedge fifoRstN) begin
    if (!fifoRstN) begin
      fifoCnt  <= 0;
      fifoWp   <= 0;
      fifoRp   <= 0;
      fifoDout <= 8'h00;
    end else begin
      if (fifoWrEn && fifoCnt < 32) begin
        fifoMem[fifoWp] <= fifoWrData;
        fifoWp          <= (fifoWp + 1) % 32;
      end
      if (bus.fifo_rd_en && fifoCnt > 0) begin
        fifoDout <= fifoMem[fifoRp];
        fifoRp   <= (fifoRp + 1) % 32;
      end
      fifoCnt <= fifoCnt + ((fifoWrEn && fifoCnt < 32) ? 1 : 0)
                 - ((bus.fifo_rd_en && fifoCnt > 0) ? 1 : 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Invariants every cycle, plus scoreboard pop on each handshake about to complete.
  task automatic observe();
    checkOutput("rdEnWhileEmpty", 32'(bus.fifo_rd_en & bus.fifo_empty), 32'd0);
    checkOutput("creditLimit", 32'((int'(bus.level) + int'(lastRdEn)) <= 2), 32'd1);
    if (bus.out_valid === 1'b1 && outReady && !flushSig) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWord", 32'd1, 32'd0);
      end else begin
        checkOutput("sbData", 32'(bus.out_data), 32'(expQ.pop_front()));
      end
      popCount++;
    end
    lastRdEn = bus.fifo_rd_en;
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic rdy);
    @(negedge clk);
    #1;
    fifoWrEn   = wr;
    fifoWrData = data;
    outReady   = rdy;
    flushSig   = flushReq;
    if (wr) expQ.push_back(data);
    #1;
    observe();
  endtask

  initial begin
    int written, startPop, cycles;
    logic wr;
    checks = 0; errors = 0; popCount = 0; lastRdEn = 1'b0;
    fifoWrEn = 1'b0; fifoWrData = 8'h00; outReady = 1'b0;
    flushSig = 1'b0; flushReq = 1'b0;
    rst_n = 1'b1; fifoRstN = 1'b1;
    #1;
    rst_n = 1'b0; fifoRstN = 1'b0;
    #2;
    checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstLevel", 32'(bus.level), 32'd0);
    checkOutput("rstRdEn", 32'(bus.fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1; fifoRstN = 1'b1;

    $display("[TB] latency");
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("latRdEnT0", 32'(bus.fifo_rd_en), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("latRdEnT1", 32'(bus.fifo_rd_en), 32'd1);
    checkOutput("latValidT1", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("latValidT2", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("latValidT3", 32'(bus.out_valid), 32'd1);
    checkOutput("latDataT3", 32'(bus.out_data), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("latDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] streaming");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("streamNoGap", 32'(bus.out_valid), 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("streamDoneValid", 32'(bus.out_valid), 32'd0);
    checkOutput("streamDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] backpressure");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("bpLevel", 32'(bus.level), 32'd2);
      checkOutput("bpRdEn", 32'(bus.fifo_rd_en), 32'd0);
      checkOutput("bpHoldData", 32'(bus.out_data), 32'h00);
      checkOutput("bpValid", 32'(bus.out_valid), 32'd1);
    end
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("bpDrained", 32'(expQ.size()), 32'd0);

`ifdef FIFO_RD_STREAM_FLUSH_EN
    $display("[TB] flush");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("flushPreRdEn", 32'(bus.fifo_rd_en), 32'd1);
    flushReq = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("flushRdEn", 32'(bus.fifo_rd_en), 32'd0);
    flushReq = 1'b0;
    // Buffered 0x41 and in-flight 0x42 are discarded by the flush.
    void'(expQ.pop_front());
    void'(expQ.pop_front());
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("flushValid", 32'(bus.out_valid), 32'd0);
    checkOutput("flushLevel", 32'(bus.level), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("flushDrained", 32'(expQ.size()), 32'd0);
`endif

    $display("[TB] random");
    written = 0;
    cycles = 0;
    startPop = popCount;
    while ((popCount - startPop) < 5000 && cycles < 40000) begin
      wr = (written < 5000) && (fifoCnt < 30) && ($urandom_range(0, 1) == 1);
      applyStimulus(wr, 8'($urandom), 1'($urandom_range(0, 1)));
      if (wr) written++;
      cycles++;
    end
    checkOutput("randomWords", 32'(popCount - startPop), 32'd5000);
    checkOutput("randomDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] async reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("preRstLevel", 32'(bus.level), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("asyncRstRdEn", 32'(bus.fifo_rd_en), 32'd0);
    checkOutput("asyncRstLevel", 32'(bus.level), 32'd0);
    fifoRstN = 1'b0;
    expQ.delete();
    lastRdEn = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1; fifoRstN = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postRstValid", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
